pd_accum_ctrl: RTL and testbench

//  Sequencer for the power-detect accumulator datapath (pd_adder_pipeline). Tracks the slot index (antenna x subframe-address)
//  and accumulation round of each input sample and drives lo/hi RAM read/write addresses and clear strobes.

---
 rtl/pd_accum_ctrl.sv | 143 ++++++++++++++
 tb/tb_pd_accum_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pd_accum_ctrl.sv
// Slot/round sequencer for the power-detect accumulator datapath: a tag shift pipe
// tracks every accepted sample and drives RAM addresses, clears and result tags.
module pd_accum_ctrl #(
    parameter int SF_ADDR_NUM = 20,
    parameter int ANT_NUM     = 4,
    parameter int ADNW        = 7,
    parameter int ACC_NUM     = 16,
    parameter int RD_LEAD     = 1,
    parameter int LO_DLY      = 3,
    parameter int HI_DLY      = 4,
    parameter int OUT_DLY     = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            lo_clr,
    output logic            hi_clr,
    output logic [ADNW-1:0] lo_waddr,
    output logic [ADNW-1:0] lo_raddr,
    output logic [ADNW-1:0] hi_waddr,
    output logic [ADNW-1:0] hi_raddr,
    output logic            o_res_valid,
    output logic [ADNW-1:0] o_res_addr,
    output logic            o_busy,
    output logic            o_done
);
    localparam int DEPTH = SF_ADDR_NUM * ANT_NUM;
    localparam int RW    = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
    localparam logic [ADNW-1:0] SCRATCH    = '1;
    localparam logic [ADNW-1:0] LAST_SLOT  = ADNW'(DEPTH - 1);
    localparam logic [RW-1:0]   LAST_ROUND = RW'(ACC_NUM - 1);

    // A slot must not be read again before its previous write lands, and
    // the scratch address must never alias a real slot.
    if ((DEPTH <= HI_DLY + 1) || ((2 ** ADNW) - 1 < DEPTH) || (ACC_NUM < 1) ||
        (RD_LEAD < 0) || (LO_DLY - RD_LEAD < 1) || (HI_DLY - RD_LEAD < 1) ||
        (OUT_DLY < HI_DLY) || (OUT_DLY < LO_DLY)) begin : g_param_err
        $error("pd_accum_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    typedef struct packed {
        logic            valid;
        logic            first;
        logic            last;
        logic [ADNW-1:0] slot;
    } tag_t;

    state_t          state_q, state_d;
    logic [ADNW-1:0] slot_q, slot_d;
    logic [RW-1:0]   round_q, round_d;
    tag_t            pipe_q [1:OUT_DLY];
    tag_t            pipe_d [1:OUT_DLY];

    logic accept;
    logic last_sample;
    logic drain_end;
    tag_t out_tag;

    assign out_tag     = pipe_q[OUT_DLY];
    assign accept      = i_valid && (state_q == S_ACCUM) && !i_abort;
    assign last_sample = accept && (slot_q == LAST_SLOT) && (round_q == LAST_ROUND);
    assign drain_end   = (state_q == S_DRAIN) && out_tag.valid && out_tag.last &&
                         (out_tag.slot == LAST_SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            round_q <= '0;
            for (int k = 1; k <= OUT_DLY; k++) pipe_q[k] <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            round_q <= round_d;
            for (int k = 1; k <= OUT_DLY; k++) pipe_q[k] <= pipe_d[k];
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (i_start) state_d = S_ACCUM;
                S_ACCUM: if (last_sample) state_d = S_DRAIN;
                S_DRAIN: if (drain_end) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counters sit at zero whenever no job is running, so a new job always starts at slot 0, round 0.
    always_comb begin
        slot_d  = slot_q;
        round_d = round_q;
        if (i_abort || (state_q == S_IDLE)) begin
            slot_d  = '0;
            round_d = '0;
        end else if (accept) begin
            if (slot_q == LAST_SLOT) begin
                slot_d  = '0;
                round_d = (round_q == LAST_ROUND) ? '0 : round_q + RW'(1);
            end else begin
                slot_d = slot_q + ADNW'(1);
            end
        end
    end

    always_comb begin
        pipe_d[1] = '0;
        if (accept) begin
            pipe_d[1].valid = 1'b1;
            pipe_d[1].first = (round_q == '0);
            pipe_d[1].last  = (round_q == LAST_ROUND);
            pipe_d[1].slot  = slot_q;
        end
        for (int k = 2; k <= OUT_DLY; k++) pipe_d[k] = pipe_q[k-1];
        if (i_abort) begin
            for (int k = 1; k <= OUT_DLY; k++) pipe_d[k] = '0;
        end
    end

    always_comb begin
        o_ready     = (state_q == S_ACCUM);
        o_busy      = (state_q != S_IDLE);
        o_done      = drain_end && !i_abort;
        lo_waddr    = pipe_q[LO_DLY].valid ? pipe_q[LO_DLY].slot : SCRATCH;
        lo_clr      = pipe_q[LO_DLY].valid && pipe_q[LO_DLY].first;
        hi_waddr    = pipe_q[HI_DLY].valid ? pipe_q[HI_DLY].slot : SCRATCH;
        hi_clr      = pipe_q[HI_DLY].valid && pipe_q[HI_DLY].first;
        lo_raddr    = pipe_q[LO_DLY-RD_LEAD].valid ? pipe_q[LO_DLY-RD_LEAD].slot : SCRATCH;
        hi_raddr    = pipe_q[HI_DLY-RD_LEAD].valid ? pipe_q[HI_DLY-RD_LEAD].slot : SCRATCH;
        o_res_valid = out_tag.valid && out_tag.last;
        o_res_addr  = o_res_valid ? out_tag.slot : '0;
    end

endmodule

// File: tb/tb_pd_accum_ctrl.sv
// Bench for pd_accum_ctrl: a cycle table on a small ACC_NUM=1 instance plus
// full-size job sequences checked every cycle against a bench-side accept history.
module tb_pd_accum_ctrl;
    localparam int DEPTH = 80;
    localparam int ACC   = 16;
    localparam int JOB   = DEPTH * ACC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 0, abort = 0, valid = 0;
    logic       ready, lclr, hclr, rv, busy, done;
    logic [6:0] lw, lr, hw, hr, ra;

    logic       s_start = 0, s_abort = 0, s_valid = 0;
    logic       s_ready, s_lclr, s_hclr, s_rv, s_busy, s_done;
    logic [2:0] s_lw, s_lr, s_hw, s_hr, s_ra;

    pd_accum_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_valid(valid),
        .o_ready(ready), .lo_clr(lclr), .hi_clr(hclr), .lo_waddr(lw), .lo_raddr(lr),
        .hi_waddr(hw), .hi_raddr(hr), .o_res_valid(rv), .o_res_addr(ra),
        .o_busy(busy), .o_done(done)
    );

    pd_accum_ctrl #(.SF_ADDR_NUM(3), .ANT_NUM(2), .ADNW(3), .ACC_NUM(1)) u_small (
        .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_abort(s_abort), .i_valid(s_valid),
        .o_ready(s_ready), .lo_clr(s_lclr), .hi_clr(s_hclr), .lo_waddr(s_lw), .lo_raddr(s_lr),
        .hi_waddr(s_hw), .hi_raddr(s_hr), .o_res_valid(s_rv), .o_res_addr(s_ra),
        .o_busy(s_busy), .o_done(s_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] act=%h exp=%h", name, idx, act, exp);
        end
    endtask

    // ---------------- small instance table ----------------
    typedef struct {
        logic st, ab, vl;
        logic rdy, bsy, dn, lc, hc, rvv;
        logic [2:0] lw, lr, hw, hr, ra;
    } vec_t;

    function automatic vec_t mk(input logic st, ab, vl, rdy, bsy, dn, lc, hc, rvv,
                                input logic [2:0] w0, r0, w1, r1, a);
        vec_t v;
        v.st = st; v.ab = ab; v.vl = vl; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
        v.lc = lc; v.hc = hc; v.rvv = rvv; v.lw = w0; v.lr = r0; v.hw = w1; v.hr = r1; v.ra = a;
        return v;
    endfunction

    // ---------------- main instance history model ----------------
    logic       hv [0:8191];
    logic       hf [0:8191];
    logic       hl [0:8191];
    logic [6:0] hs [0:8191];
    int cyc = 0, base = 0, k_acc = 0, n_done = 0;
    logic [6:0] exp_q[$];

    function automatic logic tv(input int idx);
        return (idx >= base) && hv[idx];
    endfunction

    function automatic logic [6:0] ta(input int idx);
        return tv(idx) ? hs[idx] : 7'd127;
    endfunction

    task automatic main_cycle(input logic st, ab, vl, input logic e_rdy, e_bsy, e_dn);
        logic [40:0] e, a;
        logic        e_rv;
        int          s;
        @(negedge clk);
        start = st; abort = ab; valid = vl;
        #1;
        e_rv = tv(cyc-5) && hl[cyc-5];
        e = {e_rdy, e_bsy, e_dn, tv(cyc-3) && hf[cyc-3], tv(cyc-4) && hf[cyc-4], e_rv,
             ta(cyc-3), ta(cyc-2), ta(cyc-4), ta(cyc-3), e_rv ? hs[cyc-5] : 7'd0};
        a = {ready, busy, done, lclr, hclr, rv, lw, lr, hw, hr, rv ? ra : 7'd0};
        check("cycle", cyc, 64'(a), 64'(e));
        if (rv) begin
            if (exp_q.size() == 0) check("res_extra", cyc, 64'(ra), 64'h7f);
            else check("res_slot", cyc, 64'(ra), 64'(exp_q.pop_front()));
        end
        if (done) n_done++;
        hv[cyc] = vl && e_rdy && !ab;
        hf[cyc] = 1'b0; hl[cyc] = 1'b0; hs[cyc] = 7'd0;
        if (hv[cyc]) begin
            s = k_acc % DEPTH;
            hs[cyc] = 7'(s);
            hf[cyc] = (k_acc / DEPTH) == 0;
            hl[cyc] = (k_acc / DEPTH) == ACC - 1;
            if (hl[cyc]) exp_q.push_back(7'(s));
            k_acc++;
        end
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) main_cycle(0, 0, 0, 0, 0, 0);
    endtask

    // mode: 0 back-to-back, 1 drop every 3rd cycle; abort_at: accept index to abort on (-1 none)
    task automatic run_job(input int mode, input int abort_at, input bit rst_drain);
        int n = 0;
        logic vl;
        k_acc = 0; n_done = 0;
        main_cycle(1, 0, 0, 0, 0, 0);
        while (k_acc < JOB) begin
            vl = (mode == 1) ? (n % 3 != 2) : 1'b1;
            if (vl && k_acc == abort_at) begin
                main_cycle(0, 1, 1, 1, 1, 0);
                base = cyc; exp_q.delete();
                idle_cycles(10);
                check("abort_done", 0, 64'(n_done), 64'd0);
                return;
            end
            main_cycle(n == 100, 0, vl, 1, 1, 0);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            main_cycle(0, 0, 0, 0, 1, i == 4);
            if (rst_drain && i == 2) begin
                #1 rst_n = 0;
                #1 check("rst_async", 0,
                         64'({ready, busy, done, lclr, hclr, rv, lw, lr, hw, hr, ra}),
                         64'({6'b0, 7'd127, 7'd127, 7'd127, 7'd127, 7'd0}));
                @(negedge clk);
                rst_n = 1;
                base = cyc; exp_q.delete();
                idle_cycles(3);
                check("rst_done", 0, 64'(n_done), 64'd0);
                return;
            end
        end
        idle_cycles(1);
        check("res_left", 0, 64'(exp_q.size()), 64'd0);
        check("done_count", 0, 64'(n_done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[20];
        vecs[0]  = mk(1,0,0, 0,0,0,0,0,0, 7,7,7,7,0);
        vecs[1]  = mk(0,0,1, 1,1,0,0,0,0, 7,7,7,7,0);
        vecs[2]  = mk(0,0,1, 1,1,0,0,0,0, 7,7,7,7,0);
        vecs[3]  = mk(0,0,0, 1,1,0,0,0,0, 7,0,7,7,0);
        vecs[4]  = mk(1,0,1, 1,1,0,1,0,0, 0,1,7,0,0);
        vecs[5]  = mk(0,0,1, 1,1,0,1,1,0, 1,7,0,1,0);
        vecs[6]  = mk(0,0,1, 1,1,0,0,1,1, 7,2,1,7,0);
        vecs[7]  = mk(0,0,1, 1,1,0,1,0,1, 2,3,7,2,1);
        vecs[8]  = mk(0,0,1, 0,1,0,1,1,0, 3,4,2,3,0);
        vecs[9]  = mk(0,0,0, 0,1,0,1,1,1, 4,5,3,4,2);
        vecs[10] = mk(0,0,0, 0,1,0,1,1,1, 5,7,4,5,3);
        vecs[11] = mk(0,0,0, 0,1,0,0,1,1, 7,7,5,7,4);
        vecs[12] = mk(0,0,0, 0,1,1,0,0,1, 7,7,7,7,5);
        vecs[13] = mk(1,1,0, 0,0,0,0,0,0, 7,7,7,7,0);
        vecs[14] = mk(1,0,1, 0,0,0,0,0,0, 7,7,7,7,0);
        vecs[15] = mk(0,0,1, 1,1,0,0,0,0, 7,7,7,7,0);
        vecs[16] = mk(0,0,1, 1,1,0,0,0,0, 7,7,7,7,0);
        vecs[17] = mk(0,1,1, 1,1,0,0,0,0, 7,0,7,7,0);
        vecs[18] = mk(0,0,0, 0,0,0,0,0,0, 7,7,7,7,0);
        vecs[19] = mk(0,0,1, 0,0,0,0,0,0, 7,7,7,7,0);

        repeat (3) @(negedge clk);
        rst_n = 1;

        idle_cycles(20);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_start = vecs[i].st; s_abort = vecs[i].ab; s_valid = vecs[i].vl;
            #1;
            check("small_vec", i,
                  64'({s_ready, s_busy, s_done, s_lclr, s_hclr, s_rv, s_lw, s_lr, s_hw, s_hr,
                       s_rv ? s_ra : 3'd0}),
                  64'({vecs[i].rdy, vecs[i].bsy, vecs[i].dn, vecs[i].lc, vecs[i].hc, vecs[i].rvv,
                       vecs[i].lw, vecs[i].lr, vecs[i].hw, vecs[i].hr, vecs[i].ra}));
        end
        @(negedge clk);
        s_start = 0; s_abort = 0; s_valid = 0;

        run_job(0, -1, 0);
        run_job(1, -1, 0);

        main_cycle(1, 1, 0, 0, 0, 0);
        main_cycle(0, 0, 1, 0, 0, 0);

        run_job(0, 5 * DEPTH + 40, 0);
        run_job(1, -1, 0);
        run_job(0, -1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
